// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber polynomial constants, pair index type and basemul sequencer states
package kyber_pkg;
  localparam int KYBER_N = 256;
  localparam int NPAIR = 128;
  localparam int ZETA_BASE = 64;
  typedef logic [6:0] pair_idx_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} basemul_state_t;
endpackage

// File: rtl/issue_pipe.sv
// issue_pipe: enabled delay line of DEPTH stages carrying an issue valid and its pair index
module issue_pipe
  import kyber_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  logic      vld_i,
  input  pair_idx_t idx_i,
  output logic      first_vld_o,
  output logic      pre_vld_o,
  output pair_idx_t pre_idx_o,
  output logic      last_vld_o,
  output pair_idx_t last_idx_o
);
  logic [DEPTH:1] vld_q;
  pair_idx_t [DEPTH:1] idx_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else if (en_i) begin
      vld_q <= {vld_q[DEPTH-1:1], vld_i};
      idx_q <= {idx_q[DEPTH-1:1], idx_i};
    end
  end
  assign first_vld_o = vld_q[1];
  assign pre_vld_o   = vld_q[DEPTH-1];
  assign pre_idx_o   = idx_q[DEPTH-1];
  assign last_vld_o  = vld_q[DEPTH];
  assign last_idx_o  = idx_q[DEPTH];
endmodule

// File: rtl/poly_basemul_ctrl.sv
// poly_basemul_ctrl: streams 128 coefficient pairs through the basemul datapath and writes r.
// Optional accumulate write-back enabled by BASEMUL_CTRL_ACC_EN.
module poly_basemul_ctrl
  import kyber_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int NPAIR = 128
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  logic      start,
`ifdef BASEMUL_CTRL_ACC_EN
  input  logic      acc,
  output logic      wr_acc,
`endif
  output logic      busy,
  output logic      done,
  output logic      rd_en,
  output pair_idx_t rd_addr,
  output pair_idx_t zeta_addr,
  output logic      zeta_neg,
  output logic      bm_valid,
  output logic      wr_en,
  output pair_idx_t wr_addr
);
  localparam pair_idx_t LAST = pair_idx_t'(NPAIR - 1);
  basemul_state_t state_q;
  pair_idx_t p_q, rd_addr_q, zeta_addr_q, pre_idx;
  logic busy_q, done_q, rd_en_q, zeta_neg_q, pre_vld;
  logic drained;
`ifdef BASEMUL_CTRL_ACC_EN
  logic acc_q;
  assign wr_acc = acc_q & wr_en;
`endif
  // the final write is about to leave the pipe once the last pair sits one stage before write-back
  assign drained = pre_vld && pre_idx == LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      zeta_addr_q <= '0;
      zeta_neg_q  <= 1'b0;
`ifdef BASEMUL_CTRL_ACC_EN
      acc_q       <= 1'b0;
`endif
    end else if (enable) begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          p_q     <= '0;
`ifdef BASEMUL_CTRL_ACC_EN
          acc_q   <= acc;
`endif
        end
        RUN: begin
          busy_q      <= 1'b1;
          rd_en_q     <= 1'b1;
          rd_addr_q   <= p_q;
          zeta_addr_q <= pair_idx_t'(ZETA_BASE) + (p_q >> 1);
          zeta_neg_q  <= p_q[0];
          if (p_q == LAST) state_q <= DRAIN;
          else p_q <= p_q + 7'd1;
        end
        DRAIN: if (drained) state_q <= DONE;
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
`ifdef BASEMUL_CTRL_ACC_EN
          acc_q   <= 1'b0;
`endif
        end
      endcase
    end
  end
  issue_pipe #(.DEPTH(1 + LAT)) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .en_i       (enable),
    .vld_i      (rd_en_q),
    .idx_i      (rd_addr_q),
    .first_vld_o(bm_valid),
    .pre_vld_o  (pre_vld),
    .pre_idx_o  (pre_idx),
    .last_vld_o (wr_en),
    .last_idx_o (wr_addr)
  );
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign zeta_addr = zeta_addr_q;
  assign zeta_neg  = zeta_neg_q;
endmodule

// File: tb/tb_poly_basemul_ctrl.sv
// tb_poly_basemul_ctrl: directed table and sequence checks of the basemul sequencer with LAT=3
module tb_poly_basemul_ctrl;
  import kyber_pkg::*;
  localparam int LAT = 3;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, start = 1'b0;
`ifdef BASEMUL_CTRL_ACC_EN
  logic acc = 1'b0, wr_acc;
`endif
  logic busy, done, rd_en, zeta_neg, bm_valid, wr_en;
  pair_idx_t rd_addr, zeta_addr, wr_addr;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {
    logic busy, done, rd_en, bm_valid, wr_en, wr_acc, zeta_neg;
    logic [6:0] rd_addr, zeta_addr, wr_addr;
  } snap_t;
  typedef struct {int cyc; snap_t exp;} vec_t;
  snap_t hist[200];
  vec_t tbl[12];
  poly_basemul_ctrl #(.LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .start    (start),
`ifdef BASEMUL_CTRL_ACC_EN
    .acc      (acc),
    .wr_acc   (wr_acc),
`endif
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .zeta_addr(zeta_addr),
    .zeta_neg (zeta_neg),
    .bm_valid (bm_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr)
  );
  always #5 clk = ~clk;
  function automatic snap_t sample();
    snap_t s;
    s = '0;
    s.busy = busy; s.done = done; s.rd_en = rd_en; s.bm_valid = bm_valid; s.wr_en = wr_en;
    s.zeta_neg = zeta_neg; s.rd_addr = rd_addr; s.zeta_addr = zeta_addr; s.wr_addr = wr_addr;
`ifdef BASEMUL_CTRL_ACC_EN
    s.wr_acc = wr_acc;
`endif
    return s;
  endfunction
  function automatic snap_t mask(snap_t s);
    if (!s.rd_en) begin s.rd_addr = '0; s.zeta_addr = '0; s.zeta_neg = 1'b0; end
    if (!s.wr_en) s.wr_addr = '0;
    return s;
  endfunction
  // expected outputs at stall-free cycle e after the start edge
  function automatic snap_t model(int e, bit acc_v);
    snap_t m;
    m = '0;
    m.rd_en    = e >= 1 && e <= 128;
    m.bm_valid = e >= 2 && e <= 129;
    m.wr_en    = e >= 2 + LAT && e <= 129 + LAT;
    m.busy     = e >= 1 && e <= 129 + LAT;
    m.done     = e == 130 + LAT;
    if (m.rd_en) begin
      m.rd_addr = 7'(e - 1); m.zeta_addr = 7'(64 + (e - 1) / 2); m.zeta_neg = 1'((e - 1) % 2);
    end
    if (m.wr_en) m.wr_addr = 7'(e - 2 - LAT);
`ifdef BASEMUL_CTRL_ACC_EN
    m.wr_acc = acc_v & m.wr_en;
`else
    m.wr_acc = acc_v & 1'b0;
`endif
    return m;
  endfunction
  function automatic vec_t mk(int cyc, bit b, bit d, bit r, bit v, bit w, bit n, int ra, int za, int wa);
    vec_t t;
    t.cyc = cyc;
    t.exp = '0;
    t.exp.busy = b; t.exp.done = d; t.exp.rd_en = r; t.exp.bm_valid = v; t.exp.wr_en = w;
    t.exp.zeta_neg = n; t.exp.rd_addr = 7'(ra); t.exp.zeta_addr = 7'(za); t.exp.wr_addr = 7'(wa);
    return t;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input int stall_at, input int stall_len, input bit pokes, input bit acc_v, input int abort_at);
    int endc, e, e_prev, n_rd, n_wr, n_done, done_cyc, act;
    snap_t s;
    endc = 130 + LAT + stall_len;
    e_prev = -1; n_rd = 0; n_wr = 0; n_done = 0; done_cyc = -1;
    start = 1'b1;
`ifdef BASEMUL_CTRL_ACC_EN
    acc = acc_v;
`endif
    @(posedge clk);
    for (int c = 0; c <= endc; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      e = (stall_len == 0 || c < stall_at) ? c : (c < stall_at + stall_len ? stall_at - 1 : c - stall_len);
      s = sample();
      hist[c] = s;
      chk($sformatf("cyc%0d", c), mask(s), model(e, acc_v));
      if (e != e_prev) begin
        n_rd += int'(s.rd_en); n_wr += int'(s.wr_en); n_done += int'(s.done);
        if (s.done && done_cyc < 0) done_cyc = c;
      end
      e_prev = e;
      if (c == abort_at) begin
        #1 rst = 1'b1;
        #1 chk("rst_async_clear", sample(), '0);
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        repeat (200) begin
          @(negedge clk);
          act += int'(busy | done | rd_en | wr_en | bm_valid);
        end
        chk("no_activity_after_rst", act, 0);
        return;
      end
      enable = !(stall_len > 0 && c + 1 >= stall_at && c + 1 < stall_at + stall_len);
      start = pokes && (c + 1 == 10 || c + 1 == endc);
    end
    chk("rd_pulses", n_rd, 128);
    chk("wr_pulses", n_wr, 128);
    chk("done_pulses", n_done, 1);
    chk("done_cycle", done_cyc, endc);
  endtask
  initial begin
    tbl[0]  = mk(0,   0, 0, 0, 0, 0, 0, 0,   0,   0);
    tbl[1]  = mk(1,   1, 0, 1, 0, 0, 0, 0,   64,  0);
    tbl[2]  = mk(2,   1, 0, 1, 1, 0, 1, 1,   64,  0);
    tbl[3]  = mk(3,   1, 0, 1, 1, 0, 0, 2,   65,  0);
    tbl[4]  = mk(4,   1, 0, 1, 1, 0, 1, 3,   65,  0);
    tbl[5]  = mk(5,   1, 0, 1, 1, 1, 0, 4,   66,  0);
    tbl[6]  = mk(127, 1, 0, 1, 1, 1, 0, 126, 127, 122);
    tbl[7]  = mk(128, 1, 0, 1, 1, 1, 1, 127, 127, 123);
    tbl[8]  = mk(129, 1, 0, 0, 1, 1, 0, 0,   0,   124);
    tbl[9]  = mk(130, 1, 0, 0, 0, 1, 0, 0,   0,   125);
    tbl[10] = mk(132, 1, 0, 0, 0, 1, 0, 0,   0,   127);
    tbl[11] = mk(133, 0, 1, 0, 0, 0, 0, 0,   0,   0);
    repeat (3) @(negedge clk);
    chk("reset_values", sample(), '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_op(0, 0, 0, 0, -1);
    foreach (tbl[i]) chk($sformatf("tbl_cyc%0d", tbl[i].cyc), mask(hist[tbl[i].cyc]), tbl[i].exp);
    repeat (3) @(negedge clk);
    run_op(50, 5, 0, 0, -1);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    run_op(0, 0, 1, 0, -1);
    run_op(0, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    run_op(0, 0, 0, 0, 70);
    repeat (2) @(negedge clk);
    run_op(0, 0, 0, 0, -1);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("start_while_disabled_ignored", {busy, rd_en, bm_valid}, 3'b000);
    run_op(0, 0, 0, 1, -1);
    repeat (2) @(negedge clk);
    run_op(0, 0, 0, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
